// File: rtl/aibcr3aux_osc_div_mon.sv
// Divided-oscillator frequency monitor: counts divclk rising edges over a window
// of clkin cycles and flags whether the count stays inside [lo_thr, hi_thr].
module aibcr3aux_osc_div_mon #(
    parameter int WIN_W  = 10,
    parameter int CNT_W  = 10,
    parameter int PASS_N = 2
) (
    input  logic             clkin,
    input  logic             irstb,
    input  logic             divclk,
    input  logic             mon_en,
    input  logic [WIN_W-1:0] win_len,
    input  logic [CNT_W-1:0] lo_thr,
    input  logic [CNT_W-1:0] hi_thr,
    output logic [CNT_W-1:0] edge_cnt,
    output logic             meas_done,
    output logic             osc_ok,
    output logic             osc_fail
);

    localparam int STRK_W = (PASS_N < 2) ? 1 : $clog2(PASS_N + 1);
    localparam logic [STRK_W-1:0] STRK_MAX = STRK_W'(PASS_N);

    typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, EVAL} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              sync1;
    logic              sync2;
    logic              hist;
    logic              edge_det;
    logic [1:0]        settle_cnt;
    logic [WIN_W-1:0]  meas_cnt;
    logic [WIN_W-1:0]  win_last;
    logic              meas_last;
    logic [CNT_W-1:0]  run_cnt;
    logic [STRK_W-1:0] streak;
    logic [STRK_W-1:0] streak_nxt;
    logic              pass;
    logic              eval_go;

    // divclk is only ever sampled as data; the third flop gives the edge history.
    always_ff @(posedge clkin or negedge irstb) begin
        if (!irstb) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            hist  <= 1'b0;
        end else begin
            sync1 <= divclk;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    assign edge_det  = sync2 & ~hist;
    assign win_last  = (win_len == '0) ? '0 : win_len - WIN_W'(1);
    assign meas_last = (meas_cnt == win_last);
    assign pass      = (run_cnt >= lo_thr) && (run_cnt <= hi_thr);
    assign eval_go   = (state == EVAL) && mon_en;

    always_comb begin
        streak_nxt = '0;
        if (pass) begin
            streak_nxt = (streak == STRK_MAX) ? STRK_MAX : streak + STRK_W'(1);
        end
    end

    always_ff @(posedge clkin or negedge irstb) begin
        if (!irstb) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (mon_en) state_nxt = SETTLE;
            SETTLE:  if (settle_cnt == 2'd2) state_nxt = MEASURE;
            MEASURE: if (meas_last) state_nxt = EVAL;
            EVAL:    state_nxt = MEASURE;
            default: state_nxt = IDLE;
        endcase
        if (!mon_en) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clkin or negedge irstb) begin
        if (!irstb) begin
            settle_cnt <= '0;
            meas_cnt   <= '0;
        end else begin
            settle_cnt <= (state == SETTLE && mon_en) ? settle_cnt + 2'd1 : 2'd0;
            meas_cnt   <= (state == MEASURE && mon_en && !meas_last) ? meas_cnt + WIN_W'(1) : '0;
        end
    end

    // An edge seen during EVAL seeds the next window so no edge is lost.
    always_ff @(posedge clkin or negedge irstb) begin
        if (!irstb) begin
            run_cnt <= '0;
        end else if (!mon_en) begin
            run_cnt <= '0;
        end else begin
            case (state)
                MEASURE: if (edge_det && run_cnt != '1) run_cnt <= run_cnt + CNT_W'(1);
                EVAL:    run_cnt <= edge_det ? CNT_W'(1) : '0;
                default: run_cnt <= '0;
            endcase
        end
    end

    always_ff @(posedge clkin or negedge irstb) begin
        if (!irstb) begin
            edge_cnt  <= '0;
            meas_done <= 1'b0;
            osc_ok    <= 1'b0;
            osc_fail  <= 1'b0;
            streak    <= '0;
        end else begin
            meas_done <= eval_go;
            if (!mon_en) begin
                osc_ok   <= 1'b0;
                osc_fail <= 1'b0;
                streak   <= '0;
            end else if (eval_go) begin
                edge_cnt <= run_cnt;
                osc_fail <= ~pass;
                streak   <= streak_nxt;
                osc_ok   <= (streak_nxt == STRK_MAX);
            end
        end
    end

endmodule

// File: tb/tb_aibcr3aux_osc_div_mon.sv
// Directed bench for aibcr3aux_osc_div_mon: window timing, thresholds, saturation,
// mon_en abort and asynchronous reset, with hand-computed expectations.
module tb_aibcr3aux_osc_div_mon;

    logic       clkin = 1'b0;
    logic       irstb = 1'b0;
    logic       divclk = 1'b0;
    logic       divclkFast = 1'b0;
    logic       monEn = 1'b0;
    logic [9:0] winLen = '0;
    logic [9:0] loThr = '0;
    logic [9:0] hiThr = '0;
    logic [9:0] edgeCnt;
    logic       measDone;
    logic       oscOk;
    logic       oscFail;

    logic       monEn8 = 1'b0;
    logic [9:0] winLen8 = '0;
    logic [7:0] loThr8 = '0;
    logic [7:0] hiThr8 = '0;
    logic [7:0] edgeCnt8;
    logic       measDone8;
    logic       oscOk8;
    logic       oscFail8;

    int divMode = 0;
    int divPhase = 0;
    int vecCount = 0;
    int missCount = 0;

    aibcr3aux_osc_div_mon dut (
        .clkin(clkin), .irstb(irstb), .divclk(divclk), .mon_en(monEn),
        .win_len(winLen), .lo_thr(loThr), .hi_thr(hiThr),
        .edge_cnt(edgeCnt), .meas_done(measDone), .osc_ok(oscOk), .osc_fail(oscFail)
    );

    // Narrow-counter instance used only for the saturation case.
    aibcr3aux_osc_div_mon #(.WIN_W(10), .CNT_W(8), .PASS_N(2)) dut8 (
        .clkin(clkin), .irstb(irstb), .divclk(divclkFast), .mon_en(monEn8),
        .win_len(winLen8), .lo_thr(loThr8), .hi_thr(hiThr8),
        .edge_cnt(edgeCnt8), .meas_done(measDone8), .osc_ok(oscOk8), .osc_fail(oscFail8)
    );

    always #5 clkin = ~clkin;

    // divclk changes on the falling clkin edge, well away from the sampling edge.
    // divMode 1 gives clkin/8, divMode 0 holds it low.
    always @(negedge clkin) begin
        if (divMode == 0) begin
            divclk = 1'b0;
            divPhase = 0;
        end else if (divPhase == 3) begin
            divclk = ~divclk;
            divPhase = 0;
        end else begin
            divPhase = divPhase + 1;
        end
    end

    // clkin/2 for the saturation instance.
    always @(negedge clkin) divclkFast = ~divclkFast;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        vecCount = vecCount + 1;
        if (observed != expected) begin
            missCount = missCount + 1;
            $display("[TB] FAIL %s: got %0d, want %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input int win, input int lo, input int hi);
        monEn  = en;
        winLen = 10'(win);
        loThr  = 10'(lo);
        hiThr  = 10'(hi);
    endtask

    task automatic tick();
        @(posedge clkin);
        #1;
    endtask

    // Returns the tick count to the next meas_done, or limit+1 on timeout.
    task automatic waitDone(input bit narrow, input int limit, output int cycles);
        cycles = limit + 1;
        for (int i = 1; i <= limit; i++) begin
            tick();
            if ((narrow ? measDone8 : measDone) == 1'b1) begin
                cycles = i;
                break;
            end
        end
    endtask

    initial begin
        int cyc;
        int doneSeen;

        $display("[TB] start");
        repeat (3) tick();
        checkOutput("rst_edge_cnt", int'(edgeCnt), 0);
        checkOutput("rst_meas_done", int'(measDone), 0);
        checkOutput("rst_osc_ok", int'(oscOk), 0);
        checkOutput("rst_osc_fail", int'(oscFail), 0);
        checkOutput("rst_edge_cnt8", int'(edgeCnt8), 0);

        // Nominal clkin/8: 3 settle + 64 measure + eval + 1 -> first done at tick 69.
        divMode = 1;
        irstb = 1'b1;
        repeat (20) tick();
        applyStimulus(1'b1, 64, 7, 9);
        waitDone(1'b0, 200, cyc);
        checkOutput("nom_first_latency", cyc, 69);
        checkOutput("nom_cnt_range1", int'(edgeCnt >= 8 && edgeCnt <= 9), 1);
        checkOutput("nom_fail1", int'(oscFail), 0);
        checkOutput("nom_ok1", int'(oscOk), 0);
        tick();
        checkOutput("nom_done_pulse", int'(measDone), 0);
        waitDone(1'b0, 200, cyc);
        checkOutput("nom_period", cyc + 1, 65);
        checkOutput("nom_cnt_range2", int'(edgeCnt >= 8 && edgeCnt <= 9), 1);
        checkOutput("nom_ok2", int'(oscOk), 1);
        checkOutput("nom_fail2", int'(oscFail), 0);

        // Stop divclk; the window in flight may still see a late edge, so skip it.
        divMode = 0;
        waitDone(1'b0, 200, cyc);
        checkOutput("stop_period", cyc, 65);
        waitDone(1'b0, 200, cyc);
        checkOutput("stop_period2", cyc, 65);
        checkOutput("stop_edge_cnt", int'(edgeCnt), 0);
        checkOutput("stop_fail", int'(oscFail), 1);
        checkOutput("stop_ok", int'(oscOk), 0);

        // Abort at MEASURE cycle 30 after two passing windows of exactly 8 edges.
        applyStimulus(1'b0, 64, 7, 9);
        divMode = 1;
        repeat (20) tick();
        applyStimulus(1'b1, 64, 7, 9);
        waitDone(1'b0, 200, cyc);
        checkOutput("abort_latency", cyc, 69);
        checkOutput("abort_cnt1", int'(edgeCnt), 8);
        waitDone(1'b0, 200, cyc);
        checkOutput("abort_ok_before", int'(oscOk), 1);
        repeat (29) tick();
        applyStimulus(1'b0, 64, 7, 9);
        tick();
        checkOutput("abort_ok", int'(oscOk), 0);
        checkOutput("abort_fail", int'(oscFail), 0);
        checkOutput("abort_edge_hold", int'(edgeCnt), 8);
        doneSeen = 0;
        repeat (80) begin
            tick();
            if (measDone) doneSeen = doneSeen + 1;
        end
        checkOutput("abort_no_done", doneSeen, 0);
        applyStimulus(1'b1, 64, 7, 9);
        waitDone(1'b0, 200, cyc);
        checkOutput("reenable_latency", cyc, 69);

        // Drop mon_en on the last MEASURE cycle: no EVAL, no update.
        repeat (63) tick();
        applyStimulus(1'b0, 64, 7, 9);
        doneSeen = 0;
        repeat (5) begin
            tick();
            if (measDone) doneSeen = doneSeen + 1;
        end
        checkOutput("lastcyc_no_done", doneSeen, 0);
        checkOutput("lastcyc_edge_hold", int'(edgeCnt), 8);
        checkOutput("lastcyc_fail", int'(oscFail), 0);

        // win_len=0 acts as 1; lo>hi fails every window.
        applyStimulus(1'b1, 0, 3, 2);
        waitDone(1'b0, 50, cyc);
        checkOutput("w0_first_latency", cyc, 6);
        checkOutput("w0_fail0", int'(oscFail), 1);
        for (int w = 1; w <= 4; w++) begin
            waitDone(1'b0, 10, cyc);
            checkOutput($sformatf("w0_period%0d", w), cyc, 2);
            checkOutput($sformatf("w0_fail%0d", w), int'(oscFail), 1);
            checkOutput($sformatf("w0_ok%0d", w), int'(oscOk), 0);
        end

        // Asynchronous reset mid-MEASURE after the monitor has reported OK.
        applyStimulus(1'b0, 64, 7, 9);
        tick();
        applyStimulus(1'b1, 64, 7, 9);
        waitDone(1'b0, 200, cyc);
        waitDone(1'b0, 200, cyc);
        checkOutput("arst_ok_before", int'(oscOk), 1);
        repeat (20) tick();
        #2 irstb = 1'b0;
        #2;
        checkOutput("arst_edge_cnt", int'(edgeCnt), 0);
        checkOutput("arst_meas_done", int'(measDone), 0);
        checkOutput("arst_osc_ok", int'(oscOk), 0);
        checkOutput("arst_osc_fail", int'(oscFail), 0);
        #2 irstb = 1'b1;
        waitDone(1'b0, 200, cyc);
        checkOutput("arst_restart_latency", cyc, 69);
        applyStimulus(1'b0, 64, 7, 9);

        // Saturation on the 8-bit instance with clkin/2 over 1023 cycles.
        winLen8 = 10'd1023;
        loThr8  = 8'd200;
        hiThr8  = 8'd255;
        tick();
        monEn8 = 1'b1;
        waitDone(1'b1, 1100, cyc);
        checkOutput("sat_latency", cyc, 1028);
        checkOutput("sat_edge_cnt", int'(edgeCnt8), 255);
        checkOutput("sat_fail", int'(oscFail8), 0);
        checkOutput("sat_ok", int'(oscOk8), 0);
        monEn8 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/aibcr3aux_osc_div_mon.md
AIBCR3AUX_OSC_DIV_MON -- requirements
Module: aibcr3aux_osc_div_mon

Interface
REQ-001: The block SHALL have the parameter WIN_W, default 10, giving the window-length width in bits.
REQ-002: The block SHALL have the parameter CNT_W, default 10, giving the edge-count width in bits.
REQ-003: The block SHALL have the parameter PASS_N, default 2, giving the number of consecutive passing windows required for osc_ok.
REQ-004: Port clkin, input, 1 bit: monitor reference clock; the block SHALL have this single clock.
REQ-005: Port irstb, input, 1 bit: the block SHALL have this reset, asynchronous and active-low.
REQ-006: Port divclk, input, 1 bit: divided oscillator clock under test, asynchronous to clkin, sampled as data only.
REQ-007: Port mon_en, input, 1 bit: monitor enable, synchronous to clkin.
REQ-008: Port win_len, input, WIN_W bits: window length in clkin cycles, held static while mon_en=1.
REQ-009: Port lo_thr, input, CNT_W bits: minimum passing edge count, inclusive.
REQ-010: Port hi_thr, input, CNT_W bits: maximum passing edge count, inclusive.
REQ-011: Port edge_cnt, output, CNT_W bits: divclk rising-edge count of the last completed window.
REQ-012: Port meas_done, output, 1 bit: one-cycle pulse when edge_cnt and the status outputs update.
REQ-013: Port osc_ok, output, 1 bit: PASS_N consecutive windows within thresholds.
REQ-014: Port osc_fail, output, 1 bit: the most recent window was out of thresholds.

Function
REQ-015: divclk SHALL pass through a 2-flop synchronizer followed by a third history flop; a rising edge is detected when sync=1 and history=0.
REQ-016: The FSM SHALL implement the states IDLE, SETTLE, MEASURE and EVAL, with a registered state encoding.
REQ-017: IDLE SHALL move to SETTLE when mon_en=1, and otherwise stay in IDLE.
REQ-018: SETTLE SHALL last exactly 3 cycles to flush the synchronizer, with edges ignored, and then move to MEASURE.
REQ-019: MEASURE SHALL last exactly max(win_len,1) cycles, so win_len=0 behaves as 1; every edge detected in those cycles, including the last one, SHALL increment the running counter.
REQ-020: The running counter SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-021: EVAL SHALL last 1 cycle, latch the running counter into edge_cnt, clear the running counter, and return to MEASURE with no SETTLE and no lost cycle between windows.
REQ-022: An edge detected in the EVAL cycle SHALL be counted in the next window.
REQ-023: A window SHALL pass iff lo_thr <= count <= hi_thr, compared unsigned; if lo_thr > hi_thr, every window SHALL fail.
REQ-024: A pass-streak counter SHALL increment on a pass (saturating at PASS_N) and clear on a fail.
REQ-025: osc_ok SHALL be 1 iff the pass streak has reached PASS_N.
REQ-026: osc_fail SHALL be set on a failing window and cleared on a passing window.
REQ-027: edge_cnt, osc_ok, osc_fail and meas_done SHALL be registered and SHALL update on the clock edge that ends EVAL; meas_done is high for exactly that following cycle.
REQ-028: Deasserting mon_en in any state SHALL return the FSM to IDLE on the next edge.
REQ-029: On leaving due to mon_en=0, the running counter and pass streak SHALL clear, osc_ok and osc_fail SHALL clear, edge_cnt SHALL hold its value, and no meas_done SHALL be produced.
REQ-030: If mon_en=0 coincides with the last MEASURE cycle, no EVAL SHALL occur and no update SHALL be made.
REQ-031: Re-enabling mon_en SHALL always pass through SETTLE again.

Reset
REQ-032: On irstb=0, asynchronously: state=IDLE; synchronizer and history flops=0; running counter=0, pass streak=0, edge_cnt=0; meas_done=0, osc_ok=0, osc_fail=0.
REQ-033: Reset deassertion SHALL be used synchronously to clkin with no further sequencing; the first operation after reset SHALL start from IDLE.
REQ-034: irstb asserted mid-window SHALL discard the window with no meas_done.

Verification
REQ-035: The bench SHALL drive divclk=clkin/8, win_len=64, lo_thr=7, hi_thr=9, mon_en=1 and check: meas_done every 65 cycles, edge_cnt in {8,9}, osc_fail=0, and osc_ok=1 after the 2nd meas_done.
REQ-036: The bench SHALL stop divclk with the other settings as in REQ-035 and check that the next window gives edge_cnt=0, osc_fail=1 and osc_ok=0 in the same cycle as meas_done.
REQ-037: The bench SHALL drive divclk=clkin/2, win_len=1023, CNT_W=8 and hi_thr=255 and check that edge_cnt saturates at 255 with no wrap and that the window passes.
REQ-038: The bench SHALL deassert mon_en at MEASURE cycle 30 of 64 and check: IDLE next cycle, no meas_done, osc_ok=0, osc_fail=0, edge_cnt unchanged, and 3 SETTLE cycles on re-enable.
REQ-039: The bench SHALL drive win_len=0 and lo_thr=3, hi_thr=2 and check: a 1-cycle MEASURE, meas_done every 2 cycles, and osc_fail=1 on every window.
REQ-040: The bench SHALL pulse irstb low asynchronously mid-MEASURE and check that all outputs read 0 immediately and the FSM restarts IDLE -> SETTLE.
